selector_nch_reg: RTL
=====================

Name: selector_nch_reg

Overview:
- Parametrised, registered N-channel data selector. Successor to the 4-input, 8-bit combinational 2-bit selector.
- Generalises the data width and channel count.
- Adds valid/ready handshakes on every input and on the output.
- Adds a round-robin arbitration mode alongside the fixed-select mode.
- Sits between several producer streams and one consumer. Provides one registered output stage and a throughput of one word per cycle.

Parameters:
- WIDTH, 8: data width of each channel and of result.
- CHANNELS, 4: number of input channels. Legal range is 2..16.
- SEL_W, 2: width of select and result_channel. Must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- select  input  SEL_W  channel index used when mode=0.
- result  output  WIDTH  registered selected data.
- result_valid  output  1  result holds a word.
- result_ready  input  1  consumer accepts result.
- result_channel  output  SEL_W  index of the channel that produced result.

Behaviour:
- Reset (async on rst=1, holds while asserted):
  - result=0, result_valid=0, result_channel=0.
  - Round-robin pointer last_grant=CHANNELS-1, so channel 0 has highest priority first.
  - in_ready is all zero while rst=1.
- Slot free condition: accept = !result_valid || result_ready. This allows back-to-back transfers with no bubble.
- Transfer on channel k: in_valid[k] && in_ready[k] at a clock edge.
  - At most one in_ready bit is 1 in any cycle.
  - in_ready is 0 everywhere when accept=0.
- Mode 0 (fixed select):
  - in_ready[select]=accept; all other bits are 0. This holds regardless of in_valid.
  - If select >= CHANNELS, in_ready is all zero and nothing is loaded.
- Mode 1 (round-robin):
  - Search channels last_grant+1, last_grant+2, ... wrapping modulo CHANNELS.
  - The first k with in_valid[k]=1 wins: in_ready[k]=accept.
  - If no channel is valid, in_ready is all zero.
  - last_grant updates to k only on a completed transfer. With a single valid channel, that channel wins every cycle.
- Mode 0 transfers do not change last_grant.
- On a transfer at edge t:
  - result <= in_data[k], result_channel <= k, result_valid <= 1, visible after edge t.
  - Latency is 1 cycle from input handshake to result_valid.
- At an edge with result_valid && result_ready and no transfer: result_valid <= 0. result and result_channel retain their values.
- At an edge with drain and transfer together: the new word replaces the old one and result_valid stays 1.
- Stall (result_valid && !result_ready):
  - result, result_channel and result_valid are held stable.
  - Changes on mode, select or in_data have no effect on the held word.
- mode or select changing between cycles takes effect the same cycle, combinationally, on in_ready.
- Reset asserted mid-stream: the held word is discarded and all state returns to reset values. No transfer completes on the reset edge.
- No combinational path from in_data to result. The only combinational paths are in_valid/mode/select/result_valid/result_ready -> in_ready.

Test Plan (CHANNELS=4, WIDTH=8):
1. Reset check:
   - Stimulus: assert rst mid-cycle while result_valid=1 holding 0x5A.
   - Required: result=0x00, result_valid=0, result_channel=0 immediately, and in_ready=4'b0000 while rst=1.
2. Fixed-select sweep:
   - Stimulus: mode=0, in_data = ch0 0x11, ch1 0x22, ch2 0x33, ch3 0x44, all valid, result_ready=1, select stepping 0,1,2,3.
   - Required: result 0x11, 0x22, 0x33, 0x44 on consecutive cycles, each one cycle after its handshake, with result_channel 0,1,2,3. This matches the legacy 4:1 mapping.
3. Round-robin fairness:
   - Stimulus: mode=1, all four channels valid continuously, result_ready=1 from reset.
   - Required: grants in the order 0,1,2,3,0,1... one per cycle, with no bubbles.
4. Round-robin skip and wrap:
   - Stimulus: mode=1, only ch1 and ch3 valid after a prior grant of ch3.
   - Required: grant order 1,3,1,3; in_ready[0] and in_ready[2] are never 1.
5. Back-pressure:
   - Stimulus: result_ready=0 for 3 cycles after a load of 0x22 from ch1, while ch2 is valid with 0x33.
   - Required: result holds 0x22 and in_ready=0000 for the 3 cycles. On the cycle result_ready=1, ch2 is accepted and 0x33 appears on the next edge with result_valid continuously 1.
6. Empty and out-of-range:
   - Stimulus: mode=1 with in_valid=0000 for 2 cycles and result_ready=1.
   - Required: result_valid falls to 0 after the first edge and result keeps its last value.
   - Stimulus: CHANNELS=3 with select=3 in mode 0.
   - Required: in_ready=000 and no load occurs.

Source files
------------

// File: rtl/selector_nch_reg.sv
// rtl/selector_nch_reg.sv - registered N-channel selector with fixed-select and round-robin arbitration
module selector_nch_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    output logic [WIDTH-1:0]          result,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [SEL_W-1:0]          result_channel
);

    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic [SEL_W-1:0] result_channel_q, result_channel_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic             accept;
    logic             grant_hit;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;

    assign accept = !result_valid_q || result_ready;

    // Grant choice is independent of accept so in_ready only needs one extra gate.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        if (!mode) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (SEL_W'(k) == select) begin
                    grant_hit = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
        end else begin
            for (int i = 1; i <= CHANNELS; i++) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (!grant_hit && in_valid[k] &&
                        k == (int'(last_grant_q) + i) % CHANNELS) begin
                        grant_hit = 1'b1;
                        grant_idx = SEL_W'(k);
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            in_ready[k] = !rst && accept && grant_hit && (grant_idx == SEL_W'(k));
            if (grant_idx == SEL_W'(k)) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_comb begin
        result_d         = result_q;
        result_valid_d   = result_valid_q;
        result_channel_d = result_channel_q;
        last_grant_d     = last_grant_q;
        if (xfer) begin
            result_d         = grant_data;
            result_valid_d   = 1'b1;
            result_channel_d = grant_idx;
            if (mode) begin
                last_grant_d = grant_idx;
            end
        end else if (result_ready) begin
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q         <= '0;
            result_valid_q   <= 1'b0;
            result_channel_q <= '0;
            last_grant_q     <= SEL_W'(CHANNELS - 1);
        end else begin
            result_q         <= result_d;
            result_valid_q   <= result_valid_d;
            result_channel_q <= result_channel_d;
            last_grant_q     <= last_grant_d;
        end
    end

    assign result         = result_q;
    assign result_valid   = result_valid_q;
    assign result_channel = result_channel_q;

endmodule
